// File: rtl/deskew_collector.sv
// Receive-side lane deskew: one circular buffer per lane, emitting one aligned
// N_LANE-wide vector per valid/ready transfer once every lane holds a word.
module deskew_collector #(
  parameter int N_LANE  = 4,
  parameter int DW_DATA = 8,
  parameter int DEPTH   = 8,
  parameter int AW      = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [N_LANE-1:0]           in_valid,
  input  logic [N_LANE*DW_DATA-1:0]   in_data,
  output logic [N_LANE-1:0]           in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_LANE*DW_DATA-1:0]   out_data,
  output logic [N_LANE*(AW+1)-1:0]    lane_level,
  output logic                        overflow
);

  // Handshake: a lane word is taken when in_valid[i] && in_ready[i]; a vector
  // leaves when out_valid && out_ready. in_ready and out_valid depend only on
  // registered counts, so neither side sees a combinational path from the other.

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [N_LANE-1:0] nonempty;
  logic              pop;
  logic              clear;

  assign clear     = reset || flush;
  assign out_valid = &nonempty;
  assign pop       = out_valid && out_ready;

  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    logic [DW_DATA-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               push;

    assign in_ready[g] = (count != FULL);
    assign nonempty[g] = (count != '0);
    assign push        = in_valid[g] && in_ready[g];

    always_ff @(posedge clk) begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= in_data[g*DW_DATA +: DW_DATA];
    end

    assign out_data[g*DW_DATA +: DW_DATA] = nonempty[g] ? mem[rd_ptr] : '0;
    assign lane_level[g*(AW+1) +: AW+1]   = count;
  end

  // A drop is a write strobe on a lane that was full at the start of the cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (!flush && |(in_valid & ~in_ready)) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_deskew_collector.sv
// Bench for deskew_collector: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a per-lane queue model.
module tb_deskew_collector;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;

  logic               clk;
  logic               reset;
  logic               flush;
  logic [N-1:0]       in_valid;
  logic [N*W-1:0]     in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [N*W-1:0]     out_data;
  logic [N*(A+1)-1:0] lane_level;
  logic               overflow;

  int errors = 0;
  int checks = 0;

  deskew_collector #(.N_LANE(N), .DW_DATA(W), .DEPTH(D), .AW(A)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .lane_level(lane_level), .overflow(overflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: one expected queue per lane holding words received, in order
  logic [W-1:0] exp_q [N][$];
  logic         exp_ovf = 1'b0;
  bit           started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
      exp_ovf = 1'b0;
      started = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      bit do_pop;
      do_pop = out_ready;
      for (int i = 0; i < N; i++) if (exp_q[i].size() == 0) do_pop = 0;
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) begin
          if (exp_q[i].size() >= D) exp_ovf = 1'b1;
          else exp_q[i].push_back(in_data[i*W +: W]);
        end
      end
      if (do_pop) for (int i = 0; i < N; i++) void'(exp_q[i].pop_front());
    end
  end

  // compare process: every output is meaningful on every cycle after reset
  always @(negedge clk) begin
    if (started) begin
      logic               e_valid;
      logic [N*W-1:0]     e_data;
      logic [N-1:0]       e_rdy;
      logic [N*(A+1)-1:0] e_lvl;
      e_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        int sz;
        sz = exp_q[i].size();
        if (sz == 0) e_valid = 1'b0;
        e_data[i*W +: W]         = (sz == 0) ? '0 : exp_q[i][0];
        e_rdy[i]                 = (sz < D);
        e_lvl[i*(A+1) +: (A+1)]  = (A+1)'(sz);
      end
      check("m_out_valid", 64'(out_valid), 64'(e_valid));
      check("m_out_data", 64'(out_data), 64'(e_data));
      check("m_in_ready", 64'(in_ready), 64'(e_rdy));
      check("m_lane_level", 64'(lane_level), 64'(e_lvl));
      check("m_overflow", 64'(overflow), 64'(exp_ovf));
    end
  end

  // driver: inputs change at the falling edge; return at the next falling
  // edge, when the outputs reflect the rising edge that consumed them
  task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d,
                     input logic ordy, input logic fl, input logic rst);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(negedge clk);
  endtask

  function automatic logic [N*W-1:0] rep(input logic [W-1:0] base);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = base + W'(i);
    return r;
  endfunction

  initial begin
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    int             lvl [N];
    in_valid = '0; in_data = '0; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;
    @(negedge clk);
    cyc('0, '0, 1'b0, 1'b0, 1'b1);
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'hf);
    check("rst_lane_level", 64'(lane_level), 64'h0);
    check("rst_overflow", 64'(overflow), 64'd0);

    // skewed burst: lane i gets 10+i, 20+i, 30+i starting at step i
    for (int c = 0; c < 8; c++) begin
      v = '0; d = '0;
      for (int i = 0; i < N; i++) begin
        if (c - i >= 0 && c - i < 3) begin
          v[i] = 1'b1;
          d[i*W +: W] = W'(16 * (c - i + 1) + i);
        end
      end
      cyc(v, d, 1'b1, 1'b0, 1'b0);
      if (c == 2) check("skew_not_yet", 64'(out_valid), 64'd0);
      if (c == 3) check("skew_vec0", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h13121110});
      if (c == 4) check("skew_vec1", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h23222120});
      if (c == 5) check("skew_vec2", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h33323130});
      if (c == 6) check("skew_drained", 64'(out_valid), 64'd0);
    end

    // backpressure: lane 0 fills while the head vector stays put
    cyc('1, rep(8'h10), 1'b0, 1'b0, 1'b0);
    cyc('1, rep(8'h20), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc(4'b0001, {24'd0, 8'h30 + 8'(k)}, 1'b0, 1'b0, 1'b0);
      check("bp_hold", 64'(out_data), 64'h13121110);
    end
    check("bp_full_ready", 64'(in_ready), 64'he);
    check("bp_full_level", 64'(lane_level), 64'h2228);
    cyc(4'b0001, {24'd0, 8'h99}, 1'b0, 1'b0, 1'b0);
    check("bp_ovf", 64'(overflow), 64'd1);
    check("bp_ovf_level", 64'(lane_level), 64'h2228);

    // full lane with a concurrent pop: the write still drops
    cyc(4'b0001, {24'd0, 8'haa}, 1'b1, 1'b0, 1'b0);
    check("pop_full_level", 64'(lane_level), 64'h1117);
    cyc(4'b0001, {24'd0, 8'hbb}, 1'b1, 1'b0, 1'b0);
    check("push_pop_level", 64'(lane_level), 64'h0007);

    // flush mid-stream with levels {2,3,1,5}, overflow already set
    cyc('0, '0, 1'b0, 1'b1, 1'b0);
    lvl = '{2, 3, 1, 5};
    for (int k = 0; k < 5; k++) begin
      v = '0;
      for (int i = 0; i < N; i++) v[i] = (k < lvl[i]);
      cyc(v, rep(8'h40 + 8'(16 * k)), 1'b0, 1'b0, 1'b0);
    end
    check("fl_levels", 64'(lane_level), 64'h5132);
    cyc('1, rep(8'h77), 1'b1, 1'b1, 1'b0);
    check("fl_cleared", {62'd0, out_valid, overflow}, 64'd1);
    check("fl_level0", 64'(lane_level), 64'h0);
    cyc('1, rep(8'h60), 1'b0, 1'b0, 1'b0);
    check("fl_realign", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h63626160});

    // reset while a vector is pending
    cyc('0, '0, 1'b0, 1'b0, 1'b1);
    check("rst2_out", {28'd0, in_ready, out_valid, overflow, out_data}, {28'd0, 4'hf, 1'b0, 1'b0, 32'h0});
    check("rst2_level", 64'(lane_level), 64'h0);

    // randomized traffic, fill/drain pressure varying by phase
    for (int p = 0; p < 12; p++) begin
      int rdy_pct, val_pct;
      rdy_pct = $urandom_range(10, 100);
      val_pct = $urandom_range(20, 100);
      for (int k = 0; k < 200; k++) begin
        v = '0;
        for (int i = 0; i < N; i++) v[i] = ($urandom_range(1, 100) <= val_pct);
        d = {$urandom()};
        cyc(v, d, $urandom_range(1, 100) <= rdy_pct,
            $urandom_range(0, 149) == 0, $urandom_range(0, 599) == 0);
      end
    end
    cyc('0, '0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/deskew_collector.md
Name: deskew_collector

Overview:
- Receive end of the skewed-lane datapath. Upstream injection lanes stagger data by lane index, so lane i arrives i cycles late.
- This block buffers each lane independently, re-aligns the words and emits one aligned N_LANE-wide vector per transfer on a valid/ready output.
- Sits between systolic-array column outputs and the result write-back path.

Parameters:
- N_LANE, 4, number of lanes/columns.
- DW_DATA, 8, bits per lane word.
- DEPTH, 8, per-lane buffer depth in entries; power of two, >= N_LANE.
- AW, 3, pointer width, log2(DEPTH).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- flush  in  1  synchronous clear of all lane buffers; same effect as reset except overflow is kept.
- in_valid  in  N_LANE  per-lane write strobe.
- in_data  in  N_LANE*DW_DATA  lane i at bits [i*DW_DATA +: DW_DATA].
- in_ready  out  N_LANE  lane i not full; a function of state only, no comb path from out_ready.
- out_valid  out  1  aligned vector available.
- out_ready  in  1  downstream accepts vector.
- out_data  out  N_LANE*DW_DATA  aligned vector, lane i at bits [i*DW_DATA +: DW_DATA].
- lane_level  out  N_LANE*(AW+1)  per-lane occupancy count, 0..DEPTH.
- overflow  out  1  sticky: a write hit a full lane.

Behaviour:
- Per lane: circular buffer with wr_ptr and rd_ptr (AW bits, wrap DEPTH-1 -> 0) and count (AW+1 bits).
- Reset, and flush: all pointers and counts go to 0. Then out_valid=0, in_ready=all ones, lane_level=0, out_data=0.
  - Reset clears overflow to 0; flush does not touch overflow.
  - Flush has priority over same-cycle pushes and pops; those are discarded.
- Push on lane i: in_valid[i] && count_i<DEPTH. Writes in_data lane i at wr_ptr_i, then wr_ptr_i++.
- Drop on lane i: in_valid[i] && count_i==DEPTH. The word is discarded, overflow<=1, and lane state is unchanged.
  - A pop in the same cycle does not rescue the word, because in_ready is state-only.
- out_valid: high when every count_i>=1; combinational from registered counts.
- out_data: lane i word read at rd_ptr_i.
  - Shows 0 on any lane whose count is 0.
  - Must hold stable while out_valid && !out_ready.
- Pop: out_valid && out_ready. All lanes advance rd_ptr together; lanes are never popped individually.
- Count update per lane:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; allowed when count is 1..DEPTH-1.
- Latency: the last missing lane word written at edge t gives out_valid=1 in cycle t+1. No bypass from in_data to out_data.
- Throughput: one vector per cycle when all lanes are fed each cycle and out_ready=1.
- Ordering: per-lane FIFO order is preserved. Vector k contains the k-th word received on each lane since the last reset or flush.
- No state machine beyond the pointers and counters; no X on any output after reset.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=4'b1111, lane_level all 0, overflow=0.
- Skewed burst: lane i receives values 8'h10+i, 8'h20+i, 8'h30+i starting at cycle i, with out_ready=1.
  - First out_valid comes one cycle after lane 3's first write.
  - Vectors out are {13,12,11,10}, {23,22,21,20}, {33,32,31,30}, in consecutive cycles.
- Backpressure: out_ready=0 while lanes fill.
  - out_data holds {13,12,11,10} stable.
  - Lane 0 reaches level 8 and in_ready[0]=0; a 9th lane-0 write sets overflow=1 and level stays 8.
- Full lane with concurrent pop: lane 0 at 8, out_ready=1, in_valid[0]=1.
  - Write is dropped and lane 0 level goes to 7.
  - Next cycle with in_ready[0]=1, push plus pop holds level 7.
- Flush mid-stream with lane levels {2,3,1,5} and overflow=1.
  - After one cycle: all levels 0, out_valid=0, overflow=1.
  - Next aligned write on all lanes gives out_valid one cycle later.
- Reset asserted while out_valid=1 -> next cycle all outputs at reset values, including overflow=0.
